// File: rtl/pattern_fifo_loader_if.sv
// pattern_fifo_loader_if: host write port and decoder read port of the pattern FIFO
interface pattern_fifo_loader_if #(
  parameter int N_CHANNELS = 24,
  parameter int CHANNEL_WIDTH = 4,
  parameter int CMD_WIDTH = 32,
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH_LOG2 = 6
);
  logic [WORD_WIDTH-1:0] wr_data;
  logic wr_valid;
  logic wr_ready;
  logic flush;
  logic [CMD_WIDTH-1:0] cmd;
  logic [N_CHANNELS*CHANNEL_WIDTH-1:0] pattern;
  logic rd_en;
  logic empty;
  logic full;
  logic [DEPTH_LOG2:0] level;
  logic underflow;
  modport master (
    output wr_data, wr_valid, flush, rd_en,
    input wr_ready, cmd, pattern, empty, full, level, underflow
  );
  modport slave (
    input wr_data, wr_valid, flush, rd_en,
    output wr_ready, cmd, pattern, empty, full, level, underflow
  );
endinterface

// File: rtl/pattern_fifo_loader.sv
// pattern_fifo_loader: assembles host words into cmd+pattern entries held in a show-ahead FIFO
module pattern_fifo_loader #(
  parameter int N_CHANNELS = 24,
  parameter int CHANNEL_WIDTH = 4,
  parameter int CMD_WIDTH = 32,
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH_LOG2 = 6
) (
  input logic clk,
  input logic reset,
  pattern_fifo_loader_if.slave bus
);
  localparam int PW = N_CHANNELS * CHANNEL_WIDTH;
  localparam int TW = CMD_WIDTH + PW;
  localparam int WPE = TW / WORD_WIDTH;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int IW = WPE > 1 ? $clog2(WPE) : 1;
  localparam int LW = DEPTH_LOG2 + 1;
  if (TW % WORD_WIDTH != 0) begin : g_bad_width
    $error("CMD_WIDTH + N_CHANNELS*CHANNEL_WIDTH must be a multiple of WORD_WIDTH");
  end
  logic [TW-1:0] mem [DEPTH];
  logic [TW-1:0] stage;
  logic [TW-1:0] entry_in;
  logic [TW-1:0] head;
  logic [IW-1:0] widx;
  logic [DEPTH_LOG2-1:0] wp;
  logic [DEPTH_LOG2-1:0] rp;
  logic [LW-1:0] level;
  logic [PW-1:0] held;
  logic armed;
  logic underflow;
  logic empty;
  logic full;
  logic accept;
  logic last;
  logic commit;
  logic pop;
  assign empty = level == '0;
  assign full = level == LW'(DEPTH);
  assign accept = bus.wr_valid & ~full & ~bus.flush;
  assign last = widx == IW'(WPE - 1);
  assign commit = accept & last;
  assign pop = bus.rd_en & ~empty & ~bus.flush;
  assign head = mem[rp];
  assign bus.wr_ready = ~full;
  assign bus.empty = empty;
  assign bus.full = full;
  assign bus.level = level;
  assign bus.underflow = underflow;
  assign bus.cmd = empty ? '0 : head[CMD_WIDTH-1:0];
  assign bus.pattern = empty ? held : head[TW-1:CMD_WIDTH];
  // staged entry with the incoming word dropped into its slice
  always_comb begin
    entry_in = stage;
    entry_in[widx*WORD_WIDTH +: WORD_WIDTH] = bus.wr_data;
  end
  // entry storage, written when the last word of an entry is accepted
  always_ff @(posedge clk) begin
    if (commit && !reset) mem[wp] <= entry_in;
  end
  // partial-entry staging register
  always_ff @(posedge clk) begin
    if (reset) stage <= '0;
    else if (accept) stage <= entry_in;
  end
  // pointers, level, word index and status flags
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      widx <= '0;
      wp <= '0;
      rp <= '0;
      level <= '0;
      held <= '0;
      armed <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (accept) widx <= last ? '0 : widx + 1'b1;
      if (commit) wp <= wp + 1'b1;
      if (pop) begin
        rp <= rp + 1'b1;
        held <= head[TW-1:CMD_WIDTH];
        armed <= 1'b1;
      end
      if (bus.rd_en && empty && armed) underflow <= 1'b1;
      level <= level + LW'(commit) - LW'(pop);
    end
  end
endmodule

// File: tb/tb_pattern_fifo_loader.sv
// tb_pattern_fifo_loader: directed and random checks against a queue-based model
module tb_pattern_fifo_loader;
  localparam int DL = 2;
  localparam int DEPTH = 1 << DL;
  typedef struct {
    logic [31:0] c;
    logic [95:0] p;
  } ent_t;
  logic clk = 0;
  logic reset = 1;
  int checks = 0;
  int errors = 0;
  bit chk_en = 0;
  ent_t q[$];
  logic [31:0] wb [4];
  int widx = 0;
  logic [95:0] m_last = '0;
  bit m_armed = 0;
  bit m_uf = 0;
  pattern_fifo_loader_if #(.DEPTH_LOG2(DL)) bus();
  pattern_fifo_loader #(.DEPTH_LOG2(DL)) dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(string n, logic [127:0] a, logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic model_step();
    bit emp;
    bit fl;
    if (reset || bus.flush) begin
      q.delete();
      widx = 0;
      m_armed = 0;
      m_uf = 0;
      m_last = '0;
      return;
    end
    emp = q.size() == 0;
    fl = q.size() == DEPTH;
    if (bus.rd_en && emp && m_armed) m_uf = 1;
    if (bus.rd_en && !emp) begin
      m_last = q[0].p;
      void'(q.pop_front());
      m_armed = 1;
    end
    if (bus.wr_valid && !fl) begin
      wb[widx] = bus.wr_data;
      if (widx == 3) begin
        q.push_back('{c: wb[0], p: {wb[3], wb[2], wb[1]}});
        widx = 0;
      end else widx++;
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    chk("empty", bus.empty, q.size() == 0);
    chk("full", bus.full, q.size() == DEPTH);
    chk("wr_ready", bus.wr_ready, q.size() != DEPTH);
    chk("level", bus.level, q.size());
    chk("underflow", bus.underflow, m_uf);
    chk("cmd", bus.cmd, q.size() != 0 ? q[0].c : 32'h0);
    chk("pattern", bus.pattern, q.size() != 0 ? q[0].p : m_last);
  end
  task automatic cyc(bit v, logic [31:0] d, bit r, bit f);
    bus.wr_valid = v;
    bus.wr_data = d;
    bus.rd_en = r;
    bus.flush = f;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask
  task automatic write_word(logic [31:0] d);
    bit ok;
    for (int i = 0; i < 50; i++) begin
      ok = bus.wr_ready;
      cyc(1, d, 0, 0);
      if (ok) return;
    end
    errors++;
    $display("FAIL write_word: word %h not accepted within 50 cycles", d);
  endtask
  task automatic write_entry(logic [31:0] c, logic [31:0] base);
    write_word(c);
    for (int k = 1; k < 4; k++) write_word(base + k);
  endtask
  initial begin
    bus.wr_valid = 0;
    bus.wr_data = 0;
    bus.rd_en = 0;
    bus.flush = 0;
    cyc(0, 0, 0, 0);
    chk_en = 1;
    cyc(0, 0, 1, 0);
    reset = 0;
    chk("rst_wr_ready", bus.wr_ready, 1);
    chk("rst_empty", bus.empty, 1);
    chk("rst_level", bus.level, 0);
    chk("rst_pattern", bus.pattern, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);
    chk("startup_poll_underflow", bus.underflow, 0);
    cyc(0, 0, 0, 0);
    write_word(32'h8000_0005);
    write_word(32'h1111_1111);
    write_word(32'h2222_2222);
    write_word(32'h3333_3333);
    chk("first_cmd", bus.cmd, 32'h8000_0005);
    chk("first_pattern", bus.pattern, 96'h3333_3333_2222_2222_1111_1111);
    chk("first_level", bus.level, 1);
    chk("first_empty", bus.empty, 0);
    write_entry(32'h0000_0002, 32'hA000_0000);
    write_entry(32'h0000_0003, 32'hB000_0000);
    chk("three_level", bus.level, 3);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
    chk("drained_empty", bus.empty, 1);
    chk("drained_cmd", bus.cmd, 0);
    chk("drained_pattern", bus.pattern, 96'hB000_0003_B000_0002_B000_0001);
    cyc(0, 0, 0, 1);
    for (int e = 0; e < 4; e++) write_entry(32'h10 + e, 32'hC000_0000 + (e << 8));
    chk("full_flag", bus.full, 1);
    chk("full_ready", bus.wr_ready, 0);
    cyc(1, 32'h0000_0055, 1, 0);
    chk("ready_after_pop", bus.wr_ready, 1);
    chk("level_after_pop", bus.level, 3);
    write_entry(32'h0000_0055, 32'hD000_0000);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
    chk("fifth_cmd", bus.cmd, 32'h0000_0055);
    chk("fifth_pattern", bus.pattern, 96'hD000_0003_D000_0002_D000_0001);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    chk("armed_underflow", bus.underflow, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("underflow_sticky", bus.underflow, 1);
    cyc(0, 0, 0, 1);
    chk("flush_underflow", bus.underflow, 0);
    write_word(32'hEEEE_0000);
    write_word(32'hEEEE_0001);
    cyc(1, 32'hEEEE_0002, 0, 1);
    write_entry(32'h0000_0077, 32'hF000_0000);
    chk("realign_cmd", bus.cmd, 32'h0000_0077);
    chk("realign_level", bus.level, 1);
    write_word(32'h0000_0088);
    write_word(32'h8800_0001);
    write_word(32'h8800_0002);
    cyc(1, 32'h8800_0003, 1, 0);
    chk("commit_pop_level", bus.level, 1);
    chk("commit_pop_head", bus.cmd, 32'h0000_0088);
    cyc(0, 0, 1, 0);
    write_word(32'h0000_0099);
    write_word(32'h9900_0001);
    write_word(32'h9900_0002);
    cyc(1, 32'h9900_0003, 1, 0);
    chk("commit_empty_underflow", bus.underflow, 1);
    chk("commit_empty_level", bus.level, 1);
    chk("commit_empty_cmd", bus.cmd, 32'h0000_0099);
    for (int ph = 0; ph < 4; ph++) begin
      int rp;
      rp = ph == 0 ? 10 : ph == 2 ? 90 : 50;
      for (int i = 0; i < 1000; i++) begin
        reset = $urandom_range(0, 499) == 0;
        cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 99) < rp,
            $urandom_range(0, 199) == 0);
      end
    end
    reset = 0;
    cyc(0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
